// File: rtl/add_accum_pipe_pkg.sv
// Shared definitions for the add/accumulate pipeline: operating modes and
// the helpers that decode them.
package add_accum_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ACC     = 2'd2,
      MODE_ACC_SAT = 2'd3
   } mode_e;

   function automatic logic mode_is_acc(mode_e m);
      return (m == MODE_ACC) || (m == MODE_ACC_SAT);
   endfunction

   function automatic logic mode_is_sat(mode_e m);
      return (m == MODE_SAT) || (m == MODE_ACC_SAT);
   endfunction

   // With accumulation disabled, modes 2/3 fold onto their plain counterparts.
   function automatic mode_e mode_fold(logic [1:0] raw, bit acc_en);
      return acc_en ? mode_e'(raw) : mode_e'({1'b0, raw[0]});
   endfunction

endpackage

// File: rtl/add_accum_pipe_if.sv
// Operand/result stream bundle for add_accum_pipe. The master drives operands
// and consumes results; the slave is the pipeline.
interface add_accum_pipe_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   mode;
   logic         acc_clr;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         ovf;

   modport master (
      output in_valid, a, b, mode, acc_clr, out_ready,
      input  in_ready, out_valid, y, ovf
   );

   modport slave (
      input  in_valid, a, b, mode, acc_clr, out_ready,
      output in_ready, out_valid, y, ovf
   );
endinterface

// File: rtl/add_accum_pipe_sat_unit.sv
// Combinational W+1-bit unsigned add with optional clamp to all-ones.
// ovf always reports the raw carry-out, clamped or not.
module add_sat_unit #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sat_i,
   output logic [W-1:0] y_o,
   output logic         ovf_o
);
   logic [W:0] sum;

   assign sum   = {1'b0, a_i} + {1'b0, b_i};
   assign ovf_o = sum[W];
   assign y_o   = (sat_i && sum[W]) ? {W{1'b1}} : sum[W-1:0];
endmodule

// File: rtl/add_accum_pipe.sv
// Two-stage valid/ready adder pipeline with wrap, saturate and accumulate modes.
// S1 holds the operand beat, S2 holds the result; the accumulator updates at S2 load.
module add_accum_pipe
   import add_accum_pipe_pkg::*;
#(
   parameter int W      = 8,
   parameter bit ACC_EN = 1'b1
) (
   input logic              clk,
   input logic              rst,
   add_accum_pipe_if.slave  bus
);
   logic         s1_valid_q, s1_valid_d;
   logic [W-1:0] s1_a_q, s1_a_d;
   logic [W-1:0] s1_b_q, s1_b_d;
   mode_e        s1_mode_q, s1_mode_d;
   logic         s2_valid_q, s2_valid_d;
   logic [W-1:0] y_q, y_d;
   logic         ovf_q, ovf_d;
   logic [W-1:0] acc_q, acc_d;

   logic         s2_load;
   logic         in_fire;
   logic         s1_acc;
   logic [W-1:0] op2;
   logic [W-1:0] sum_y;
   logic         sum_ovf;

   assign s2_load     = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign bus.in_ready = !s1_valid_q || s2_load;
   assign in_fire     = bus.in_valid && bus.in_ready;
   assign s1_acc      = mode_is_acc(s1_mode_q);

   // A clear in the same cycle as an accumulate load takes effect first.
   assign op2 = s1_acc ? (bus.acc_clr ? '0 : acc_q) : s1_b_q;

   add_sat_unit #(.W(W)) u_sat_unit (
      .a_i   (s1_a_q),
      .b_i   (op2),
      .sat_i (mode_is_sat(s1_mode_q)),
      .y_o   (sum_y),
      .ovf_o (sum_ovf)
   );

   always_comb begin
      // NOTE: every next-state value is defaulted to its current value first, so no path leaves it unassigned and no latch is inferred.
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_mode_d  = s1_mode_q;
      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      ovf_d      = ovf_q;
      acc_d      = acc_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_a_d     = bus.a;
         s1_b_d     = bus.b;
         s1_mode_d  = mode_fold(bus.mode, ACC_EN);
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         s2_valid_d = 1'b1;
         y_d        = sum_y;
         ovf_d      = sum_ovf;
      end else if (bus.out_ready) begin
         s2_valid_d = 1'b0;
      end

      if (s2_load && s1_acc) begin
         acc_d = sum_y;
      end else if (bus.acc_clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_mode_q  <= MODE_WRAP;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         ovf_q      <= 1'b0;
         acc_q      <= '0;
      end else begin
         // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         ovf_q      <= ovf_d;
         acc_q      <= acc_d;
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.y         = y_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_accum_pipe.sv
// Self-checking bench for add_accum_pipe (W=8): directed cases followed by a
// randomized run checked against a queue-based reference model.
module tb_add_accum_pipe;
   localparam int W = 8;
   localparam int unsigned MAXV = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   add_accum_pipe_if #(.W(W)) bus ();

   add_accum_pipe #(.W(W), .ACC_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic         in_fire, out_fire;
   logic [W-1:0] smp_y;
   bit           sb_en = 1'b0;
   logic [W:0]   exp_q[$];
   int unsigned  acc_m;
   logic         hold_pending = 1'b0;
   logic [W-1:0] hold_y;
   logic         hold_ovf;
   logic [W-1:0] got_q[$];
   int           k;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: the sum is computed at acceptance, accumulate beats chain in acceptance order.
   task automatic model_accept();
      int unsigned  op2, s;
      logic         o;
      logic [W-1:0] ym;
      op2 = (bus.mode >= 2'd2) ? acc_m : 32'(bus.b);
      s   = 32'(bus.a) + op2;
      o   = (s > MAXV);
      ym  = (bus.mode[0] && o) ? W'(MAXV) : W'(s);
      if (bus.mode >= 2'd2) acc_m = 32'(ym);
      exp_q.push_back({o, ym});
   endtask

   task automatic cyc();
      logic [W:0] e;
      @(negedge clk);
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      smp_y    = bus.y;
      if (sb_en) begin
         if (hold_pending) begin
            check("stall_hold_valid", 32'(bus.out_valid), 1);
            check("stall_hold_y", 32'(bus.y), 32'(hold_y));
            check("stall_hold_ovf", 32'(bus.ovf), 32'(hold_ovf));
         end
         hold_pending = bus.out_valid && !bus.out_ready;
         hold_y       = bus.y;
         hold_ovf     = bus.ovf;
         if (out_fire) begin
            check("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_y", 32'(bus.y), 32'(e[W-1:0]));
               check("sb_ovf", 32'(bus.ovf), 32'(e[W]));
            end
         end
         if (in_fire) model_accept();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input int av, input int bv, input int md,
                       input int ey, input int eovf);
      bus.in_valid = 1'b1;
      bus.a        = W'(av);
      bus.b        = W'(bv);
      bus.mode     = 2'(md);
      cyc();
      bus.in_valid = 1'b0;
      check({tag, "_accept"}, 32'(in_fire), 1);
      check({tag, "_lat1_valid"}, 32'(bus.out_valid), 0);
      cyc();
      check({tag, "_lat2_valid"}, 32'(bus.out_valid), 1);
      check({tag, "_y"}, 32'(bus.y), 32'(ey));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.mode      = 2'd0;
      bus.acc_clr   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_y", 32'(bus.y), 0);
      check("rst_ovf", 32'(bus.ovf), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      check("rst_acc", 32'(dut.acc_q), 0);

      beat("wrap_4_2", 4, 2, 0, 6, 0);
      beat("wrap_200_100", 200, 100, 0, 44, 1);
      beat("sat_200_100", 200, 100, 1, 255, 1);
      beat("sat_255_0", 255, 0, 1, 255, 0);
      beat("wrap_0_0", 0, 0, 0, 0, 0);
      beat("wrap_255_255", 255, 255, 0, 254, 1);
      beat("sat_255_255", 255, 255, 1, 255, 1);

      // Accumulate 10, 20, 30 back-to-back
      bus.mode = 2'd2; bus.b = 8'd99;
      bus.in_valid = 1'b1; bus.a = 8'd10; cyc();
      bus.a = 8'd20; cyc();
      check("acc_y10", 32'(bus.y), 10);
      bus.a = 8'd30; cyc();
      check("acc_y30", 32'(bus.y), 30);
      bus.in_valid = 1'b0; cyc();
      check("acc_y60", 32'(bus.y), 60);
      check("acc_y60_valid", 32'(bus.out_valid), 1);

      // Clear coincides with the S2 load of ACC a=5
      bus.in_valid = 1'b1; bus.a = 8'd5; cyc();
      bus.in_valid = 1'b0; bus.acc_clr = 1'b1; cyc();
      bus.acc_clr = 1'b0;
      check("clr_acc_y", 32'(bus.y), 5);
      check("clr_acc_state", 32'(dut.acc_q), 5);
      cyc();
      bus.acc_clr = 1'b1; cyc();
      bus.acc_clr = 1'b0;
      check("clr_alone_acc", 32'(dut.acc_q), 0);
      check("clr_alone_no_out", 32'(bus.out_valid), 0);

      // ACC_SAT 250 then 10
      bus.mode = 2'd3;
      bus.in_valid = 1'b1; bus.a = 8'd250; cyc();
      bus.a = 8'd10; cyc();
      check("accsat_y250", 32'(bus.y), 250);
      check("accsat_ovf0", 32'(bus.ovf), 0);
      bus.in_valid = 1'b0; cyc();
      check("accsat_y255", 32'(bus.y), 255);
      check("accsat_ovf1", 32'(bus.ovf), 1);
      cyc();

      // Backpressure: 4 stalled cycles with 3 WRAP beats (1+1, 2+2, 3+3) offered
      bus.mode = 2'd0; bus.out_ready = 1'b0; k = 0;
      for (int c = 0; c < 4; c++) begin
         bus.in_valid = (k < 3);
         bus.a = W'(k + 1); bus.b = W'(k + 1);
         cyc();
         if (in_fire) k++;
         if (c >= 1) begin
            check("stall_y_stable", 32'(bus.y), 2);
            check("stall_in_ready", 32'(bus.in_ready), 0);
         end
      end
      check("stall_accepts", 32'(k), 2);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10 && got_q.size() < 3; c++) begin
         bus.in_valid = (k < 3);
         bus.a = W'(k + 1); bus.b = W'(k + 1);
         cyc();
         if (in_fire) k++;
         if (out_fire) got_q.push_back(smp_y);
      end
      bus.in_valid = 1'b0;
      check("release_count", 32'(got_q.size()), 3);
      for (int i = 0; i < got_q.size(); i++) check("release_order", 32'(got_q[i]), 32'(2 * (i + 1)));
      cyc();
      check("release_no_dup", 32'(bus.out_valid), 0);

      // Reset with both stages full
      bus.out_ready = 1'b0; bus.mode = 2'd2;
      bus.in_valid = 1'b1; bus.a = 8'd1; cyc();
      bus.a = 8'd2; cyc();
      bus.in_valid = 1'b0;
      check("pre_rst_full", 32'(bus.out_valid), 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 0);
      check("midrst_y", 32'(bus.y), 0);
      check("midrst_ovf", 32'(bus.ovf), 0);
      check("midrst_acc", 32'(dut.acc_q), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
      check("post_rst_no_partial", 32'(bus.out_valid), 0);
      beat("post_rst_acc7", 7, 0, 2, 7, 0);

      // Randomized run against the reference model
      acc_m = 7;
      bus.acc_clr = 1'b0;
      hold_pending = 1'b0;
      sb_en = 1'b1;
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.a         = W'($urandom_range(0, MAXV));
         bus.b         = W'($urandom_range(0, MAXV));
         bus.mode      = 2'($urandom_range(0, 3));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) cyc();
      check("sb_drained", 32'(exp_q.size()), 0);
      check("sb_final_acc", 32'(dut.acc_q), acc_m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
